// File: rtl/sipo_deserializer_if.sv
// Bus bundle for the serial-to-parallel word assembler: serial input side
// (bit_in/bit_valid/clear) plus the completed-word and status outputs.
interface sipo_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int BC_W = $clog2(WIDTH + 2);

  logic             bit_in;
  logic             bit_valid;
  logic             clear;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             parity_err;
  logic             busy;
  logic [BC_W-1:0]  bit_count;
  logic [CNT_W-1:0] word_count;

  // Bit source side: supplies serial bits and consumes assembled words.
  modport master (
    output bit_in, bit_valid, clear,
    input  data_out, data_valid, parity_err, busy, bit_count, word_count
  );

  // Deserializer side.
  modport slave (
    input  bit_in, bit_valid, clear,
    output data_out, data_valid, parity_err, busy, bit_count, word_count
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out word assembler for the RS232 receive path.
// Packs WIDTH qualified bits into a word in the selected bit order,
// optionally checks a trailing parity bit, and strobes data_valid for one
// cycle after each completed word. clear aborts a partial frame.
module sipo_deserializer #(
  parameter int WIDTH      = 8,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  sipo_deserializer_if.slave bus
);

  localparam int BC_W  = $clog2(WIDTH + 2);
  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;

  logic [1:0]       state_q,      state_d;
  logic [WIDTH-1:0] shift_q,      shift_d;
  logic [WIDTH-1:0] data_out_q,   data_out_d;
  logic             parity_err_q, parity_err_d;
  logic             data_valid_q, data_valid_d;
  logic [BC_W-1:0]  bit_count_q,  bit_count_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  logic [IDX_W-1:0] pos;
  logic             complete;
  logic             par_err_calc;

  // Target bit position of the next data bit, from the frame bit index.
  always_comb begin
    if (LSB_FIRST != 0) pos = bit_count_q[IDX_W-1:0];
    else                pos = IDX_W'(WIDTH - 1) - bit_count_q[IDX_W-1:0];
  end

  // Next-state logic: framing FSM, shift register and word completion.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    data_valid_d = 1'b0;
    bit_count_d  = bit_count_q;
    word_count_d = word_count_q;
    complete     = 1'b0;
    par_err_calc = 1'b0;

    if (bus.clear) begin
      // Abort wins over any bit presented on the same edge.
      state_d     = S_IDLE;
      bit_count_d = '0;
      shift_d     = '0;
    end else if (bus.bit_valid) begin
      case (state_q)
        S_IDLE, S_DATA: begin
          shift_d[pos] = bus.bit_in;
          if (state_q == S_DATA && bit_count_q == BC_W'(WIDTH - 1)) begin
            if (PARITY_EN != 0) begin
              state_d     = S_PAR;
              bit_count_d = BC_W'(WIDTH);
            end else begin
              complete = 1'b1;
            end
          end else begin
            state_d     = S_DATA;
            bit_count_d = bit_count_q + 1'b1;
          end
        end
        S_PAR: begin
          complete     = 1'b1;
          par_err_calc = ((^shift_q) ^ bus.bit_in) != (PARITY_ODD != 0);
        end
        default: begin
          state_d     = S_IDLE;
          bit_count_d = '0;
        end
      endcase

      if (complete) begin
        state_d      = S_IDLE;
        bit_count_d  = '0;
        data_out_d   = shift_d;
        parity_err_d = (PARITY_EN != 0) && par_err_calc;
        data_valid_d = 1'b1;
        word_count_d = word_count_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      data_out_q   <= '0;
      parity_err_q <= 1'b0;
      data_valid_q <= 1'b0;
      bit_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      parity_err_q <= parity_err_d;
      data_valid_q <= data_valid_d;
      bit_count_q  <= bit_count_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.bit_count  = bit_count_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer. Five instances cover the parameter
// corners: LSB-first, MSB-first, even parity, odd parity, 2-bit word counter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic [4:0] bv;
  logic [4:0] clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(8), .CNT_W(16)) if_lsb ();
  sipo_deserializer_if #(.WIDTH(8), .CNT_W(16)) if_msb ();
  sipo_deserializer_if #(.WIDTH(8), .CNT_W(16)) if_pe ();
  sipo_deserializer_if #(.WIDTH(8), .CNT_W(16)) if_po ();
  sipo_deserializer_if #(.WIDTH(8), .CNT_W(2))  if_wr ();

  assign if_lsb.bit_in = bit_in; assign if_lsb.bit_valid = bv[0]; assign if_lsb.clear = clr[0];
  assign if_msb.bit_in = bit_in; assign if_msb.bit_valid = bv[1]; assign if_msb.clear = clr[1];
  assign if_pe.bit_in  = bit_in; assign if_pe.bit_valid  = bv[2]; assign if_pe.clear  = clr[2];
  assign if_po.bit_in  = bit_in; assign if_po.bit_valid  = bv[3]; assign if_po.clear  = clr[3];
  assign if_wr.bit_in  = bit_in; assign if_wr.bit_valid  = bv[4]; assign if_wr.clear  = clr[4];

  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0), .CNT_W(16))
    u_lsb (.clk(clk), .rst(rst), .bus(if_lsb.slave));
  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0), .CNT_W(16))
    u_msb (.clk(clk), .rst(rst), .bus(if_msb.slave));
  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0), .CNT_W(16))
    u_pe (.clk(clk), .rst(rst), .bus(if_pe.slave));
  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1), .CNT_W(16))
    u_po (.clk(clk), .rst(rst), .bus(if_po.slave));
  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0), .CNT_W(2))
    u_wr (.clk(clk), .rst(rst), .bus(if_wr.slave));

  logic [4:0] dv;
  logic [4:0] bz;
  assign dv = {if_wr.data_valid, if_po.data_valid, if_pe.data_valid, if_msb.data_valid, if_lsb.data_valid};
  assign bz = {if_wr.busy, if_po.busy, if_pe.busy, if_msb.busy, if_lsb.busy};

  // Count one comparison; report and count it when it fails.
  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one bit (optionally with clear) to instance d for one edge.
  task automatic send_bit(input int d, input logic b, input logic c);
    bit_in = b;
    bv     = '0;
    clr    = '0;
    bv[d]  = 1'b1;
    clr[d] = c;
    tick();
    bv  = '0;
    clr = '0;
  endtask

  // Send 8 bits back to back, first transmitted bit is s[0]. Mid-frame the
  // instance must be busy with no data_valid.
  task automatic send_frame(input int d, input logic [7:0] s);
    for (int k = 0; k < 8; k++) begin
      send_bit(d, s[k], 1'b0);
      if (k < 7)
        check({dv[d], bz[d]} === 2'b01,
              $sformatf("frame_mid dut%0d bit%0d: {valid,busy}=%b expected 01", d, k, {dv[d], bz[d]}));
    end
  endtask

  task automatic test_reset_state();
    check({if_lsb.data_out, if_lsb.word_count, if_lsb.bit_count} === 28'h0,
          $sformatf("reset_state_regs: got %h expected 0",
                    {if_lsb.data_out, if_lsb.word_count, if_lsb.bit_count}));
    check({dv, bz, if_pe.parity_err, if_po.parity_err} === 12'h0,
          $sformatf("reset_state_flags: got %h expected 0", {dv, bz, if_pe.parity_err, if_po.parity_err}));
  endtask

  task automatic test_reset();
    send_frame(0, 8'h3C);
    check(if_lsb.data_out === 8'h3C && if_lsb.word_count === 16'd1,
          $sformatf("pre_reset_word: data=%h cnt=%0d expected 3c/1", if_lsb.data_out, if_lsb.word_count));
    for (int k = 0; k < 3; k++) send_bit(0, 1'b1, 1'b0);
    check(if_lsb.busy === 1'b1 && if_lsb.bit_count === 4'd3,
          $sformatf("partial_frame: busy=%b cnt=%0d expected 1/3", if_lsb.busy, if_lsb.bit_count));
    #2 rst = 1'b1;
    #1;
    check({if_lsb.data_out, if_lsb.word_count, if_lsb.bit_count, if_lsb.busy, if_lsb.data_valid,
           if_lsb.parity_err} === 31'h0,
          $sformatf("async_reset: data=%h cnt=%0d bc=%0d busy=%b expected all 0",
                    if_lsb.data_out, if_lsb.word_count, if_lsb.bit_count, if_lsb.busy));
    @(negedge clk);
    rst = 1'b0;
    send_frame(0, 8'h05);
    check(if_lsb.data_valid === 1'b1 && if_lsb.data_out === 8'h05 && if_lsb.word_count === 16'd1,
          $sformatf("post_reset_word: valid=%b data=%h cnt=%0d expected 1/05/1",
                    if_lsb.data_valid, if_lsb.data_out, if_lsb.word_count));
    tick();
    check(if_lsb.data_valid === 1'b0,
          $sformatf("valid_single_pulse: got %b expected 0", if_lsb.data_valid));
  endtask

  task automatic test_bit_order();
    send_frame(1, 8'h05);
    check(if_msb.data_valid === 1'b1 && if_msb.data_out === 8'hA0,
          $sformatf("msb_first: valid=%b data=%h expected 1/a0", if_msb.data_valid, if_msb.data_out));
    send_frame(0, 8'h05);
    check(if_lsb.data_out === 8'h05 && if_lsb.word_count === 16'd2,
          $sformatf("lsb_first: data=%h cnt=%0d expected 05/2", if_lsb.data_out, if_lsb.word_count));
  endtask

  task automatic test_gapped();
    int gaps [8] = '{0, 2, 0, 3, 1, 0, 2, 3};
    logic [7:0] s;
    int pulses;
    s = 8'hC3;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        tick();
        check(if_lsb.busy === 1'b1 && if_lsb.data_valid === 1'b0,
              $sformatf("gap_hold bit%0d: busy=%b valid=%b expected 1/0", k, if_lsb.busy, if_lsb.data_valid));
      end
      send_bit(0, s[k], 1'b0);
    end
    check(if_lsb.data_valid === 1'b1 && if_lsb.data_out === 8'hC3 && if_lsb.busy === 1'b0 &&
          if_lsb.word_count === 16'd3,
          $sformatf("gapped_word: valid=%b data=%h busy=%b cnt=%0d expected 1/c3/0/3",
                    if_lsb.data_valid, if_lsb.data_out, if_lsb.busy, if_lsb.word_count));
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (if_lsb.data_valid === 1'b1) pulses++;
    end
    check(pulses == 0, $sformatf("gapped_extra_pulses: got %0d expected 0", pulses));
  endtask

  task automatic test_parity();
    send_frame(2, 8'h07);
    check(if_pe.busy === 1'b1 && if_pe.data_valid === 1'b0 && if_pe.bit_count === 4'd8,
          $sformatf("parity_wait: busy=%b valid=%b bc=%0d expected 1/0/8",
                    if_pe.busy, if_pe.data_valid, if_pe.bit_count));
    send_bit(2, 1'b1, 1'b0);
    check(if_pe.data_valid === 1'b1 && if_pe.data_out === 8'h07 && if_pe.parity_err === 1'b0 &&
          if_pe.busy === 1'b0,
          $sformatf("even_parity_ok: valid=%b data=%h perr=%b busy=%b expected 1/07/0/0",
                    if_pe.data_valid, if_pe.data_out, if_pe.parity_err, if_pe.busy));
    send_frame(2, 8'h07);
    send_bit(2, 1'b0, 1'b0);
    check(if_pe.parity_err === 1'b1 && if_pe.word_count === 16'd2,
          $sformatf("even_parity_bad: perr=%b cnt=%0d expected 1/2", if_pe.parity_err, if_pe.word_count));
    tick();
    check(if_pe.parity_err === 1'b1 && if_pe.data_valid === 1'b0,
          $sformatf("parity_err_hold: perr=%b valid=%b expected 1/0", if_pe.parity_err, if_pe.data_valid));
    send_frame(3, 8'h07);
    send_bit(3, 1'b0, 1'b0);
    check(if_po.data_valid === 1'b1 && if_po.parity_err === 1'b0,
          $sformatf("odd_parity_ok: valid=%b perr=%b expected 1/0", if_po.data_valid, if_po.parity_err));
    send_frame(3, 8'h07);
    send_bit(3, 1'b1, 1'b0);
    check(if_po.parity_err === 1'b1,
          $sformatf("odd_parity_bad: perr=%b expected 1", if_po.parity_err));
  endtask

  task automatic test_abort();
    for (int k = 0; k < 5; k++) send_bit(0, 1'b1, 1'b0);
    check(if_lsb.bit_count === 4'd5, $sformatf("abort_pre: bc=%0d expected 5", if_lsb.bit_count));
    bit_in = 1'b0;
    clr[0] = 1'b1;
    tick();
    clr = '0;
    check(if_lsb.busy === 1'b0 && if_lsb.bit_count === 4'd0 && if_lsb.data_out === 8'hC3 &&
          if_lsb.data_valid === 1'b0 && if_lsb.word_count === 16'd3,
          $sformatf("clear_abort: busy=%b bc=%0d data=%h valid=%b cnt=%0d expected 0/0/c3/0/3",
                    if_lsb.busy, if_lsb.bit_count, if_lsb.data_out, if_lsb.data_valid, if_lsb.word_count));
    for (int k = 0; k < 7; k++) send_bit(0, 1'b1, 1'b0);
    send_bit(0, 1'b1, 1'b1);
    check(if_lsb.data_valid === 1'b0 && if_lsb.busy === 1'b0 && if_lsb.data_out === 8'hC3 &&
          if_lsb.word_count === 16'd3 && if_lsb.bit_count === 4'd0,
          $sformatf("clear_on_last_bit: valid=%b busy=%b data=%h cnt=%0d bc=%0d expected 0/0/c3/3/0",
                    if_lsb.data_valid, if_lsb.busy, if_lsb.data_out, if_lsb.word_count, if_lsb.bit_count));
    send_frame(0, 8'h5A);
    check(if_lsb.data_valid === 1'b1 && if_lsb.data_out === 8'h5A && if_lsb.word_count === 16'd4,
          $sformatf("after_abort_word: valid=%b data=%h cnt=%0d expected 1/5a/4",
                    if_lsb.data_valid, if_lsb.data_out, if_lsb.word_count));
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      send_frame(4, words[i]);
      check(if_wr.data_valid === 1'b1 && if_wr.data_out === words[i] && if_wr.word_count === exp_cnt[i],
            $sformatf("back_to_back word%0d: valid=%b data=%h cnt=%0d expected 1/%h/%0d",
                      i, if_wr.data_valid, if_wr.data_out, if_wr.word_count, words[i], exp_cnt[i]));
    end
    tick();
    check(if_wr.data_valid === 1'b0 && if_wr.busy === 1'b0,
          $sformatf("back_to_back_end: valid=%b busy=%b expected 0/0", if_wr.data_valid, if_wr.busy));
  endtask

  initial begin
    rst    = 1'b1;
    bit_in = 1'b0;
    bv     = '0;
    clr    = '0;
    tick();
    test_reset_state();
    rst = 1'b0;
    tick();
    test_reset();
    test_bit_order();
    test_gapped();
    test_parity();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Parametrised serial-in/parallel-out word assembler for the RS232 receive path. It samples one serial bit per qualified clock, packs WIDTH bits into a word with selectable bit order, optionally checks a trailing parity bit, and presents the completed word with a one-cycle valid strobe. It replaces the fixed 8-bit shifter and adds framing, bit ordering, parity, abort and a word counter.

Parameters:
WIDTH, 8, data bits per word (range 2..32)
LSB_FIRST, 1, 1 = first received bit lands in data_out[0]; 0 = first bit lands in data_out[WIDTH-1]
PARITY_EN, 0, 1 = one parity bit follows the WIDTH data bits
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (used only when PARITY_EN=1)
CNT_W, 16, width of word_count

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  asynchronous, active-high reset
bit_in  in  1  serial data bit
bit_valid  in  1  bit_in is sampled on a rising edge where bit_valid=1
clear  in  1  synchronous abort of the partial word
data_out  out  WIDTH  last completed word
data_valid  out  1  one-cycle pulse: data_out/parity_err newly updated
parity_err  out  1  parity mismatch flag for the current data_out (0 when PARITY_EN=0)
busy  out  1  high while a partial word is held (state != IDLE)
bit_count  out  $clog2(WIDTH+2)  bits accepted into the current frame
word_count  out  CNT_W  completed words since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1): state=IDLE; shift register, data_out, bit_count, word_count = 0; data_valid, parity_err, busy = 0. Takes effect immediately, mid-frame partial data discarded.
- States: IDLE, DATA, PAR.
- IDLE: bit_valid=1 -> capture bit 0, bit_count=1, go DATA (when WIDTH bits complete in one step is impossible since WIDTH>=2).
- DATA: each bit_valid=1 captures next bit, bit_count+1. On the edge capturing bit WIDTH: if PARITY_EN=0 -> complete word, go IDLE; else go PAR (bit_count=WIDTH).
- PAR: next bit_valid=1 captures parity bit; complete word, go IDLE.
- Cycles with bit_valid=0 hold all state; no timeout.
- Bit order: LSB_FIRST=1 -> bit k of the frame goes to position k; LSB_FIRST=0 -> bit k goes to position WIDTH-1-k.
- Word completion (on the capturing edge): data_out <= assembled word; parity_err <= PARITY_EN & (XOR(data, parity bit) != PARITY_ODD); word_count+1; bit_count <= 0; data_valid=1 for exactly the following cycle.
- data_out and parity_err hold until the next completion; never cleared except by rst.
- Back-to-back: bit_valid=1 in the cycle data_valid is high is accepted as bit 0 of the next frame; no dead cycle required.
- clear=1: on the edge, state=IDLE, bit_count=0, partial word discarded; data_out, parity_err, word_count unchanged; data_valid not raised. clear and bit_valid together: clear wins, bit discarded. clear on the edge that would complete a word: no completion.
- busy = (state != IDLE), registered-state derived.
- word_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset: assert rst mid-frame after 3 bits -> all outputs 0 immediately; next 8 bits 1,0,1,0,0,0,0,0 (LSB_FIRST=1) -> data_out=8'h05, single data_valid pulse, word_count=1.
- Bit order: LSB_FIRST=0, stream 1,0,1,0,0,0,0,0 -> data_out=8'hA0; LSB_FIRST=1 same stream -> 8'h05.
- Gapped input: 8 bits of 0xC3 with bit_valid low 0-3 random cycles between bits -> data_out=8'hC3 exactly once, busy high from first bit to completion edge.
- Parity: PARITY_EN=1, PARITY_ODD=0, data 0x07 + parity 1 -> parity_err=0; data 0x07 + parity 0 -> parity_err=1; PARITY_ODD=1, 0x07 + parity 0 -> parity_err=0.
- Abort: 5 bits then clear -> busy=0, bit_count=0, data_out keeps prior 0xC3, no data_valid; clear with bit_valid on 8th bit -> no word produced.
- Back-to-back and wrap: CNT_W=2, four consecutive words with no idle cycle (0x11,0x22,0x33,0x44) -> four data_valid pulses 8 cycles apart, word_count 1,2,3,0.
